// File: rtl/page_align2msg_pass_if.sv
// page_align2msg_pass_if: reads extrinsic-message pages, undoes the level-2 circular shift, streams words via a 2-entry buffer.
// Define PA2MP_4BIT_EN to add a fourth bit-plane (memSrcIn_bit3_i / msgPassOut_bit3_o).
module page_align2msg_pass_if #(
  parameter int SHIFT_LENGTH = 17,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            sys_clk,
  input  logic                            rstn,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [ADDR_WIDTH-1:0]           page_num_i,
  input  logic [$clog2(SHIFT_LENGTH)-1:0] shift_factor_i,
  output logic                            mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr_o,
  input  logic [SHIFT_LENGTH-1:0]         memSrcIn_bit0_i,
  input  logic [SHIFT_LENGTH-1:0]         memSrcIn_bit1_i,
  input  logic [SHIFT_LENGTH-1:0]         memSrcIn_bit2_i,
`ifdef PA2MP_4BIT_EN
  input  logic [SHIFT_LENGTH-1:0]         memSrcIn_bit3_i,
  output logic [SHIFT_LENGTH-1:0]         msgPassOut_bit3_o,
`endif
  output logic [SHIFT_LENGTH-1:0]         msgPassOut_bit0_o,
  output logic [SHIFT_LENGTH-1:0]         msgPassOut_bit1_o,
  output logic [SHIFT_LENGTH-1:0]         msgPassOut_bit2_o,
  output logic                            msg_valid_o,
  input  logic                            msg_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            cfg_err_o
);
`ifdef PA2MP_4BIT_EN
  localparam int NP = 4;
`else
  localparam int NP = 3;
`endif
  localparam int SW = $clog2(SHIFT_LENGTH);
  localparam int DW = NP * SHIFT_LENGTH;
  localparam logic [SW:0] SLW = SHIFT_LENGTH[SW:0];
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base, r_pages, r_k;
  logic [SW-1:0] r_shift;
  logic r_err, r_inflight, r_wp, r_rp;
  logic [1:0] r_cnt;
  logic [DW-1:0] r_mem [2];
  logic [DW-1:0] w_raw, w_rot, w_head;
  logic w_start, w_issue, w_pop, w_push, w_last, w_sf_ge;
  logic [SW:0] w_sf_ext;
`ifdef PA2MP_4BIT_EN
  assign w_raw = {memSrcIn_bit3_i, memSrcIn_bit2_i, memSrcIn_bit1_i, memSrcIn_bit0_i};
  assign msgPassOut_bit3_o = w_head[3*SHIFT_LENGTH +: SHIFT_LENGTH];
`else
  assign w_raw = {memSrcIn_bit2_i, memSrcIn_bit1_i, memSrcIn_bit0_i};
`endif
  assign msgPassOut_bit0_o = w_head[0 +: SHIFT_LENGTH];
  assign msgPassOut_bit1_o = w_head[SHIFT_LENGTH +: SHIFT_LENGTH];
  assign msgPassOut_bit2_o = w_head[2*SHIFT_LENGTH +: SHIFT_LENGTH];
  // out[i] = in[(i+s) mod L]: right-rotate via a doubled word
  for (genvar p = 0; p < NP; p++) begin : g_rot
    logic [2*SHIFT_LENGTH-1:0] w_dbl;
    assign w_dbl = {2{w_raw[p*SHIFT_LENGTH +: SHIFT_LENGTH]}} >> r_shift;
    assign w_rot[p*SHIFT_LENGTH +: SHIFT_LENGTH] = w_dbl[SHIFT_LENGTH-1:0];
  end
  assign w_sf_ext = {1'b0, shift_factor_i};
  assign w_sf_ge  = w_sf_ext >= SLW;
  assign w_start  = (r_state == IDLE) && start_i;
  assign w_pop    = (r_cnt != 2'd0) && msg_ready_i;
  assign w_push   = r_inflight;
  assign w_last   = r_k == r_pages - ADDR_WIDTH'(1);
  assign w_issue  = (r_state == RUN) && ({1'b0, r_cnt} + {2'b0, r_inflight} <= 3'd1 + {2'b0, w_pop});
  assign w_head   = msg_valid_o ? r_mem[r_rp] : '0;
  always_ff @(posedge sys_clk) begin
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = (page_num_i == '0) ? DONE : RUN;
      RUN:     if (w_issue && w_last) w_next = DRAIN;
      DRAIN:   if (!r_inflight && r_cnt == {1'b0, w_pop}) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy_o        = r_state != IDLE;
    done_o        = r_state == DONE;
    mem_rd_en_o   = w_issue;
    mem_rd_addr_o = w_issue ? r_base + r_k : '0;
    msg_valid_o   = r_cnt != 2'd0;
    cfg_err_o     = r_err;
  end
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_base     <= '0;
      r_pages    <= '0;
      r_k        <= '0;
      r_shift    <= '0;
      r_err      <= 1'b0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
    end else begin
      if (w_start) begin
        r_base  <= base_addr_i;
        r_pages <= page_num_i;
        r_k     <= '0;
        r_shift <= w_sf_ge ? SW'(w_sf_ext - SLW) : shift_factor_i;
        r_err   <= w_sf_ge;
      end else if (w_issue) begin
        r_k <= r_k + ADDR_WIDTH'(1);
      end
      r_inflight <= w_issue;
      if (w_push) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wp] <= w_rot;
  end
endmodule
